// File: rtl/event_sync_arbiter_pkg.sv
// Shared constants and helpers for the asynchronous event synchroniser / round-robin arbiter slice.
package event_sync_arbiter_pkg;

  localparam int EVS_MAX_CH = 32;

  function automatic int evs_idx_w(input int n_ch);
    return (n_ch <= 1) ? 1 : $clog2(n_ch);
  endfunction

  localparam int EVS_IDX_W = evs_idx_w(EVS_MAX_CH);

  typedef logic [EVS_IDX_W-1:0] evs_idx_t;

endpackage

// File: rtl/event_sync_channel.sv
// One input channel: STAGES-deep synchroniser, previous-value register and armed-gated rising-edge output.
module event_sync_channel
  import event_sync_arbiter_pkg::*;
#(
  parameter int STAGES = 2
) (
  input  logic aclk,
  input  logic areset,
  input  logic i_s,
  input  logic i_armed,
  output logic o_edge
);

  logic [STAGES-1:0] r_sync;
  logic              r_prev;
  logic              w_sq;

  assign w_sq = r_sync[STAGES-1];

  always_ff @(posedge aclk) begin
    // NOTE: the synchroniser flops are reset as well, so sq starts from a known 0 after reset.
    if (areset) begin
      r_sync <= '0;
      r_prev <= 1'b0;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], i_s};
      r_prev <= w_sq;
    end
  end

  assign o_edge = w_sq & ~r_prev & i_armed;

endmodule

// File: rtl/event_sync_arbiter.sv
// Synchronises N_CH asynchronous event lines, latches their rising edges and serialises them
// onto a single valid/ready stream through a round-robin arbiter.
module event_sync_arbiter
  import event_sync_arbiter_pkg::*;
#(
  parameter int N_CH   = 4,
  parameter int STAGES = 2
) (
  input  logic                       aclk,
  input  logic                       areset,
  input  logic [N_CH-1:0]            s,
  output logic                       ev_valid,
  input  logic                       ev_ready,
  output logic [evs_idx_w(N_CH)-1:0] ev_idx,
  output logic [N_CH-1:0]            ovr,
  input  logic [N_CH-1:0]            ovr_clr,
  output logic                       armed
);

  localparam int IDX_W = evs_idx_w(N_CH);
  localparam int ARM_W = $clog2(STAGES + 1);

  typedef logic [IDX_W-1:0] ch_idx_t;

  if (N_CH < 1 || N_CH > EVS_MAX_CH) begin : g_bad_n_ch
    $error("event_sync_arbiter: N_CH must be within 1..%0d", EVS_MAX_CH);
  end
  if (STAGES < 2) begin : g_bad_stages
    $error("event_sync_arbiter: STAGES must be at least 2");
  end

  logic [N_CH-1:0]  w_edge;
  logic [N_CH-1:0]  w_gnt_vec;
  logic [N_CH-1:0]  r_pend;
  logic [N_CH-1:0]  r_ovr;
  logic [ARM_W-1:0] r_arm_cnt;
  logic             r_armed;
  logic             r_valid;
  ch_idx_t          r_idx;
  ch_idx_t          r_ptr;
  ch_idx_t          w_gnt_idx;
  ch_idx_t          w_ptr_nxt;
  logic             w_gnt_any;
  logic             w_free;
  logic             w_grant;

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    event_sync_channel #(
      .STAGES (STAGES)
    ) u_ch (
      .aclk    (aclk),
      .areset  (areset),
      .i_s     (s[g]),
      .i_armed (r_armed),
      .o_edge  (w_edge[g])
    );
  end

  assign w_free = ~r_valid | ev_ready;

  // Two descending passes: channels below the pointer first, then those at or above it,
  // so the lowest pending channel at/above the pointer ends up winning with wrap-around.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    w_gnt_any = 1'b0;
    w_gnt_idx = '0;
    w_gnt_vec = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (r_pend[i] && (ch_idx_t'(i) < r_ptr)) begin
        w_gnt_any = 1'b1;
        w_gnt_idx = ch_idx_t'(i);
      end
    end
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (r_pend[i] && (ch_idx_t'(i) >= r_ptr)) begin
        w_gnt_any = 1'b1;
        w_gnt_idx = ch_idx_t'(i);
      end
    end
    w_grant = w_free & w_gnt_any;
    for (int i = 0; i < N_CH; i++) begin
      w_gnt_vec[i] = w_grant && (w_gnt_idx == ch_idx_t'(i));
    end
    w_ptr_nxt = (w_gnt_idx == ch_idx_t'(N_CH - 1)) ? '0 : w_gnt_idx + ch_idx_t'(1);
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      r_arm_cnt <= '0;
      r_armed   <= 1'b0;
    end else if (!r_armed) begin
      if (r_arm_cnt == ARM_W'(STAGES)) begin
        r_armed <= 1'b1;
      end else begin
        r_arm_cnt <= r_arm_cnt + ARM_W'(1);
      end
    end
  end

  // An edge arriving in the cycle its own channel is granted is a fresh event and re-arms pending.
  always_ff @(posedge aclk) begin
    if (areset) begin
      r_pend <= '0;
      r_ovr  <= '0;
    end else begin
      r_pend <= w_edge | (r_pend & ~w_gnt_vec);
      r_ovr  <= (r_ovr & ~ovr_clr) | (w_edge & r_pend & ~w_gnt_vec);
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      r_valid <= 1'b0;
      r_idx   <= '0;
      r_ptr   <= '0;
    end else if (w_free) begin
      r_valid <= w_gnt_any;
      if (w_gnt_any) begin
        r_idx <= w_gnt_idx;
        r_ptr <= w_ptr_nxt;
      end
    end
  end

  assign ev_valid = r_valid;
  assign ev_idx   = r_idx;
  assign ovr      = r_ovr;
  assign armed    = r_armed;

endmodule
